// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef NUM_REGISTERS
`define NUM_REGISTERS 16
`endif

package regfile_pkg;

    localparam int RF_WORD_SIZE  = `WORD_SIZE;
    localparam int RF_COUNT      = `NUM_REGISTERS;
    localparam int RF_COUNT_BITS = $clog2(RF_COUNT);

    // Requester IDs in the default three-way configuration
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_DBG = 2;

    // One write-back request as carried on the flattened buses
    typedef struct packed {
        logic [RF_COUNT_BITS-1:0] idx;
        logic [RF_WORD_SIZE-1:0]  data;
    } wb_req_t;

    // Saturating increment for the 16-bit accepted-write counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester handshake and register-file write port bundle.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int WORD_SIZE  = 8,
    parameter int COUNT_BITS = 4
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*COUNT_BITS-1:0] req_idx;
    logic [NUM_REQ*WORD_SIZE-1:0]  req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          hold;
    logic                          wr_en;
    logic [COUNT_BITS-1:0]         wr_idx;
    logic [WORD_SIZE-1:0]          wr_data;
    logic [PTR_W-1:0]              last_grant;
    logic [15:0]                   grant_count;

    modport master (
        output req_valid, req_idx, req_data, hold,
        input  req_ready, wr_en, wr_idx, wr_data, last_grant, grant_count
    );

    modport slave (
        input  req_valid, req_idx, req_data, hold,
        output req_ready, wr_en, wr_idx, wr_data, last_grant, grant_count
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan from ptr upward with wrap, keep the first valid hit
    always_comb begin
        int               sum;
        logic [PTR_W-1:0] c;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = 0;
        c       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            c = PTR_W'(sum);
            if (!any && valid[c]) begin
                any     = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = c;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among requesters,
// with a one-entry registered write stage feeding en_write/idx_write/data_in.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int  WORD_SIZE  = RF_WORD_SIZE,
    parameter int  COUNT      = RF_COUNT,
    parameter int  NUM_REQ    = 3,
    localparam int COUNT_BITS = $clog2(COUNT),
    localparam int PTR_W      = $clog2(NUM_REQ)
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_t              reqs [NUM_REQ];
    logic [NUM_REQ-1:0]   valid_masked;
    logic [NUM_REQ-1:0]   gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 xfer;

    logic                 wr_en_d, wr_en_q;
    wb_req_t              stage_d, stage_q;
    logic [PTR_W-1:0]     ptr_d, ptr_q;
    logic [PTR_W-1:0]     last_grant_d, last_grant_q;
    logic [15:0]          grant_count_d, grant_count_q;

    // Unpack the flattened request buses into per-requester entries
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].idx  = bus.req_idx[i*COUNT_BITS +: COUNT_BITS];
            reqs[i].data = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    // No grants while held or in reset; the pointer still selects the order
    assign valid_masked = bus.req_valid & {NUM_REQ{~bus.hold & ~rst}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid   (valid_masked),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (xfer)
    );

    assign bus.req_ready = gnt;

    // Next-state: load the stage on a transfer, otherwise pulse wr_en low
    always_comb begin
        wr_en_d       = 1'b0;
        stage_d       = stage_q;
        ptr_d         = ptr_q;
        last_grant_d  = last_grant_q;
        grant_count_d = grant_count_q;
        if (xfer) begin
            wr_en_d       = 1'b1;
            stage_d       = reqs[gnt_idx];
            ptr_d         = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            last_grant_d  = gnt_idx;
            grant_count_d = sat_inc16(grant_count_q);
        end
    end

    // State registers; reset drops any accepted-but-unwritten entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q       <= 1'b0;
            stage_q       <= '0;
            ptr_q         <= '0;
            last_grant_q  <= '0;
            grant_count_q <= '0;
        end else begin
            wr_en_q       <= wr_en_d;
            stage_q       <= stage_d;
            ptr_q         <= ptr_d;
            last_grant_q  <= last_grant_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_idx      = stage_q.idx;
    assign bus.wr_data     = stage_q.data;
    assign bus.last_grant  = last_grant_q;
    assign bus.grant_count = grant_count_q;

endmodule
